// File: rtl/sensor_level_encoder.sv
// sensor_level_encoder
// Quantizes raw 8-bit samples from four sensor channels (rain, seismic, wind,
// water level) into 2-bit severity codes. Falling levels get a hysteresis
// margin, and a per-channel persistence filter delays any change of the
// committed level until enough consecutive samples agree.
//
// Ports:
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   sample_valid/ready valid/ready intake of {sample_ch, sample_data}
//   sample_ch         00 rain, 01 seismic, 10 wind, 11 water level
//   sample_data       unsigned raw sample
//   hold              freezes intake and all internal state
//   r1..l0            registered committed level codes (x1 = MSB)
//   code_update       one-cycle pulse after any committed code changes
module sensor_level_encoder #(
    parameter int DATA_W  = 8,
    parameter int TH1     = 64,
    parameter int TH2     = 128,
    parameter int TH3     = 192,
    parameter int HYST    = 8,
    parameter int PERSIST = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [1:0]        sample_ch,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              hold,
    output logic              r1,
    output logic              r0,
    output logic              s1,
    output logic              s0,
    output logic              w1,
    output logic              w0,
    output logic              l1,
    output logic              l0,
    output logic              code_update
);

    localparam int CNT_W = $clog2(PERSIST + 1);
    localparam logic [DATA_W-1:0] TH1_C     = DATA_W'(TH1);
    localparam logic [DATA_W-1:0] TH2_C     = DATA_W'(TH2);
    localparam logic [DATA_W-1:0] TH3_C     = DATA_W'(TH3);
    localparam logic [DATA_W:0]   HYST_C    = (DATA_W + 1)'(HYST);
    localparam logic [CNT_W-1:0]  PERSIST_C = CNT_W'(PERSIST);

    // Thresholds are inclusive upward: d == TH2 is level 2.
    function automatic logic [1:0] quant(input logic [DATA_W-1:0] d);
        logic [1:0] q;
        if (d < TH1_C) begin
            q = 2'd0;
        end else if (d < TH2_C) begin
            q = 2'd1;
        end else if (d < TH3_C) begin
            q = 2'd2;
        end else begin
            q = 2'd3;
        end
        return q;
    endfunction

    // One extra bit catches the carry; saturate to all-ones on overflow.
    function automatic logic [DATA_W-1:0] sat_add_hyst(input logic [DATA_W-1:0] d);
        logic [DATA_W:0] sum;
        logic [DATA_W-1:0] res;
        sum = {1'b0, d} + HYST_C;
        if (sum[DATA_W]) begin
            res = {DATA_W{1'b1}};
        end else begin
            res = sum[DATA_W-1:0];
        end
        return res;
    endfunction

    // Falling candidates are judged against d+HYST and never exceed L.
    function automatic logic [1:0] next_candidate(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] lvl);
        logic [1:0] q;
        logic [1:0] qh;
        logic [1:0] c;
        q  = quant(d);
        qh = quant(sat_add_hyst(d));
        if (q >= lvl) begin
            c = q;
        end else if (qh < lvl) begin
            c = qh;
        end else begin
            c = lvl;
        end
        return c;
    endfunction

    logic              ready_q, ready_d;
    logic              s1_valid_q, s1_valid_d;
    logic [1:0]        s1_ch_q, s1_ch_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [1:0]        level_q [4];
    logic [1:0]        level_d [4];
    logic [1:0]        pend_q  [4];
    logic [1:0]        pend_d  [4];
    logic [CNT_W-1:0]  cnt_q   [4];
    logic [CNT_W-1:0]  cnt_d   [4];
    logic              code_update_q, code_update_d;
    logic              accept_s;
    logic [1:0]        cand_s;
    logic [CNT_W-1:0]  cnt_next_s;

    // ready_q is low during reset and for the reset cycle itself.
    assign sample_ready = ready_q && !hold && !rst;
    assign accept_s     = sample_valid && sample_ready;

    // Next-state: stage-1 capture and stage-2 quantize/hysteresis/persistence.
    always_comb begin
        ready_d       = 1'b1;
        s1_valid_d    = s1_valid_q;
        s1_ch_d       = s1_ch_q;
        s1_data_d     = s1_data_q;
        level_d       = level_q;
        pend_d        = pend_q;
        cnt_d         = cnt_q;
        code_update_d = 1'b0;
        cand_s        = 2'd0;
        cnt_next_s    = {CNT_W{1'b0}};
        if (hold) begin
            // Everything, including a sample sitting in stage 1, stays put.
            code_update_d = 1'b0;
        end else begin
            s1_valid_d = accept_s;
            if (accept_s) begin
                s1_ch_d   = sample_ch;
                s1_data_d = sample_data;
            end else begin
                s1_ch_d   = s1_ch_q;
                s1_data_d = s1_data_q;
            end
            if (s1_valid_q) begin
                cand_s = next_candidate(s1_data_q, level_q[s1_ch_q]);
                if (cand_s == level_q[s1_ch_q]) begin
                    cnt_next_s = {CNT_W{1'b0}};
                end else if (cand_s == pend_q[s1_ch_q]) begin
                    cnt_next_s = cnt_q[s1_ch_q] + CNT_W'(1);
                end else begin
                    pend_d[s1_ch_q] = cand_s;
                    cnt_next_s      = CNT_W'(1);
                end
                if ((cand_s != level_q[s1_ch_q]) && (cnt_next_s == PERSIST_C)) begin
                    level_d[s1_ch_q] = cand_s;
                    cnt_d[s1_ch_q]   = {CNT_W{1'b0}};
                    code_update_d    = 1'b1;
                end else begin
                    cnt_d[s1_ch_q] = cnt_next_s;
                end
            end else begin
                cnt_next_s = {CNT_W{1'b0}};
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q       <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_ch_q       <= 2'd0;
            s1_data_q     <= {DATA_W{1'b0}};
            code_update_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                level_q[i] <= 2'd0;
                pend_q[i]  <= 2'd0;
                cnt_q[i]   <= {CNT_W{1'b0}};
            end
        end else begin
            ready_q       <= ready_d;
            s1_valid_q    <= s1_valid_d;
            s1_ch_q       <= s1_ch_d;
            s1_data_q     <= s1_data_d;
            code_update_q <= code_update_d;
            for (int i = 0; i < 4; i++) begin
                level_q[i] <= level_d[i];
                pend_q[i]  <= pend_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign r1          = level_q[0][1];
    assign r0          = level_q[0][0];
    assign s1          = level_q[1][1];
    assign s0          = level_q[1][0];
    assign w1          = level_q[2][1];
    assign w0          = level_q[2][0];
    assign l1          = level_q[3][1];
    assign l0          = level_q[3][0];
    assign code_update = code_update_q;

endmodule

// File: tb/tb_sensor_level_encoder.sv
// Self-checking bench for sensor_level_encoder: a behavioural model computes
// the expected codes per accepted sample into a scoreboard queue; a monitor
// pops and compares when the DUT processes that sample.
module tb_sensor_level_encoder;

    localparam int TH1 = 64, TH2 = 128, TH3 = 192, HYST = 8, PERSIST = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] sample_ch = 2'd0;
    logic [7:0] sample_data = 8'd0;
    logic       sample_ready;
    logic       r1, r0, s1, s0, w1, w0, l1, l0, code_update;
    logic [7:0] codes;

    int checks = 0;
    int failures = 0;
    int upd_cnt = 0;
    int base;

    assign codes = {r1, r0, s1, s0, w1, w0, l1, l0};

    sensor_level_encoder #(
        .DATA_W(8), .TH1(TH1), .TH2(TH2), .TH3(TH3), .HYST(HYST), .PERSIST(PERSIST)
    ) dut (
        .clk(clk), .rst(rst),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_ch(sample_ch), .sample_data(sample_data), .hold(hold),
        .r1(r1), .r0(r0), .s1(s1), .s0(s0), .w1(w1), .w0(w0), .l1(l1), .l0(l0),
        .code_update(code_update)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_lvl [4];
    int m_pend[4];
    int m_cnt [4];

    function automatic int quant_m(input int d);
        if (d >= TH3) return 3;
        else if (d >= TH2) return 2;
        else if (d >= TH1) return 1;
        else return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_lvl[i] = 0; m_pend[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_step(input int ch, input int d, output logic [8:0] e);
        int q, s, cand, upd;
        upd = 0;
        q = quant_m(d);
        if (q >= m_lvl[ch]) begin
            cand = q;
        end else begin
            s = d + HYST;
            if (s > 255) s = 255;
            cand = quant_m(s);
            if (cand > m_lvl[ch]) cand = m_lvl[ch];
        end
        if (cand == m_lvl[ch]) begin
            m_cnt[ch] = 0;
        end else begin
            if (cand == m_pend[ch]) m_cnt[ch] = m_cnt[ch] + 1;
            else begin m_pend[ch] = cand; m_cnt[ch] = 1; end
            if (m_cnt[ch] == PERSIST) begin
                m_lvl[ch] = cand; m_cnt[ch] = 0; upd = 1;
            end
        end
        e = {upd[0], m_lvl[0][1:0], m_lvl[1][1:0], m_lvl[2][1:0], m_lvl[3][1:0]};
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [8:0] sb_q[$];
    logic [7:0] cur_exp = 8'd0;
    bit         inflight = 1'b0;

    initial begin
        logic acc, h, r, proc;
        logic [1:0] ch;
        logic [7:0] d;
        logic [8:0] e;
        model_reset();
        forever begin
            @(posedge clk);
            acc = sample_valid && sample_ready;
            h = hold; r = rst; ch = sample_ch; d = sample_data;
            proc = 1'b0;
            if (r) begin
                model_reset();
                sb_q.delete();
                inflight = 1'b0;
                cur_exp = 8'd0;
            end else if (!h) begin
                proc = inflight;
                if (acc) begin
                    model_step(int'(ch), int'(d), e);
                    sb_q.push_back(e);
                end
                inflight = acc;
            end
            #1;
            if (proc) begin
                check_val("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_val("sb_codes", codes, e[7:0]);
                    check_val("sb_update", code_update, e[8]);
                    cur_exp = e[7:0];
                end
            end else begin
                check_val("idle_codes", codes, cur_exp);
                check_val("idle_update", code_update, 1'b0);
            end
            if (code_update === 1'b1) upd_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [1:0] ch, input logic [7:0] d);
        int n = 0;
        sample_valid = 1'b1; sample_ch = ch; sample_data = d;
        while (sample_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("send_ready", sample_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset with valid asserted
        rst = 1'b1; sample_valid = 1'b1; sample_ch = 2'd0; sample_data = 8'd200;
        repeat (3) begin
            @(negedge clk);
            check_val("rst_ready", sample_ready, 1'b0);
            check_val("rst_codes", codes, 8'h00);
            check_val("rst_update", code_update, 1'b0);
        end
        rst = 1'b0; sample_valid = 1'b0;
        @(negedge clk);
        check_val("ready_after_rst", sample_ready, 1'b1);

        // Rise with persistence
        base = upd_cnt;
        send(2'd0, 8'd130); idle(2); check_val("rise_s1", {r1, r0}, 2'b00);
        send(2'd0, 8'd130); idle(2); check_val("rise_s2", {r1, r0}, 2'b00);
        send(2'd0, 8'd130); idle(2); check_val("rise_s3", {r1, r0}, 2'b10);
        check_val("rise_pulses", upd_cnt - base, 1);

        // Hysteresis
        base = upd_cnt;
        repeat (3) send(2'd0, 8'd125);
        idle(2); check_val("hyst_125", {r1, r0}, 2'b10);
        repeat (3) send(2'd0, 8'd119);
        idle(2); check_val("hyst_119", {r1, r0}, 2'b01);
        check_val("hyst_pulses", upd_cnt - base, 1);

        // Interrupted persistence, back to back
        base = upd_cnt;
        send(2'd2, 8'd200); send(2'd2, 8'd200); send(2'd2, 8'd50);
        send(2'd2, 8'd200); send(2'd2, 8'd200); send(2'd2, 8'd200);
        check_val("intr_before", {w1, w0}, 2'b00);
        idle(2);
        check_val("intr_after", {w1, w0}, 2'b11);
        check_val("intr_pulses", upd_cnt - base, 1);

        // Interleaving seismic and water level
        base = upd_cnt;
        repeat (3) begin
            send(2'd1, 8'd70);
            send(2'd3, 8'd250);
        end
        idle(2);
        check_val("intl_seis", {s1, s0}, 2'b01);
        check_val("intl_water", {l1, l0}, 2'b11);
        check_val("intl_rain", {r1, r0}, 2'b01);
        check_val("intl_wind", {w1, w0}, 2'b11);
        check_val("intl_pulses", upd_cnt - base, 2);

        // Hold and reset mid-operation
        send(2'd0, 8'd250); send(2'd0, 8'd250);
        base = upd_cnt;
        hold = 1'b1; sample_valid = 1'b1; sample_ch = 2'd0; sample_data = 8'd250;
        repeat (4) begin
            @(negedge clk);
            check_val("hold_ready", sample_ready, 1'b0);
            check_val("hold_rain", {r1, r0}, 2'b01);
        end
        check_val("hold_pulses", upd_cnt - base, 0);
        hold = 1'b0; sample_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_codes", codes, 8'h00);
        send(2'd0, 8'd250);
        idle(3);
        check_val("midrst_rain", {r1, r0}, 2'b00);
        check_val("midrst_pulses", upd_cnt - base, 0);

        // Threshold boundaries (inclusive upward)
        repeat (3) send(2'd1, 8'd128);
        repeat (3) send(2'd2, 8'd63);
        repeat (3) send(2'd3, 8'd64);
        idle(2);
        check_val("bnd_th2", {s1, s0}, 2'b10);
        check_val("bnd_below_th1", {w1, w0}, 2'b00);
        check_val("bnd_th1", {l1, l0}, 2'b01);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sensor_level_encoder.md
# sensor_level_encoder

Front-end for the disaster warning device. It accepts raw 8-bit sensor samples for four channels (rain, seismic, wind, water level) over a valid/ready stream. Each sample is quantized to a 2-bit severity level, with hysteresis on falling levels and a persistence filter. The block then drives the registered `r1,r0,s1,s0,w1,w0,l1,l0` level codes that the warning logic consumes, so it is the producing end of the level-code interface.

## Interface
- `DATA_W`, 8: raw sample width.
- `TH1`, 64: level-1 threshold (inclusive).
- `TH2`, 128: level-2 threshold (inclusive).
- `TH3`, 192: level-3 threshold (inclusive).
- `HYST`, 8: hysteresis margin applied only to falling levels.
- `PERSIST`, 3: consecutive agreeing samples needed to change a committed level (≥1).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sample_valid`  in  1  a raw sample is presented.
- `sample_ready`  out  1  block can accept a sample.
- `sample_ch`  in  2  channel: 00 rain, 01 seismic, 10 wind, 11 water level.
- `sample_data`  in  DATA_W  raw sensor value (unsigned).
- `hold`  in  1  freezes intake and all state.
- `r1`,`r0`  out  1 each  rain level code (`r1` = MSB).
- `s1`,`s0`  out  1 each  seismic level code.
- `w1`,`w0`  out  1 each  wind level code.
- `l1`,`l0`  out  1 each  water-level code.
- `code_update`  out  1  one-cycle pulse when any committed code changes.

## Operation
- Accept occurs when `sample_valid && sample_ready`. `sample_ready = !rst && !hold`, and is registered low during reset.
- **Stage 1:** an accepted `{sample_ch, sample_data}` is registered with a stage-1 valid bit.
- **Stage 2:** processes the stage-1 sample against that channel's committed level L.
  - Quantize: `quant(d)` = 0 if d<TH1, 1 if d<TH2, 2 if d<TH3, else 3.
  - Hysteresis:
    - If `quant(d) ≥ L`, the candidate is `quant(d)`.
    - Otherwise the candidate is `min(L, quant(sat(d+HYST)))`.
    - The addition is DATA_W+1 bits wide and saturates at 2^DATA_W−1.
  - Per-channel state: committed level (2b), pending level (2b), counter (width clog2(PERSIST+1)).
  - Persistence rules:
    - candidate == L: counter ← 0.
    - candidate ≠ L and candidate == pending: counter ← counter+1.
    - candidate ≠ L and candidate ≠ pending: pending ← candidate, counter ← 1.
    - When the new counter value reaches PERSIST, L ← candidate and counter ← 0.
    - Multi-level jumps (e.g. 0→3) commit directly.
- Only the addressed channel's state changes. Other channels are untouched.
- Output codes are the committed levels, registered.
- `code_update` pulses for one cycle per commit. At most one commit can occur per cycle.
- `hold=1`:
  - No accept.
  - Stage 1 is not loaded.
  - Any sample already in stage 1 is held, not processed, until `hold` drops.
  - `code_update` stays 0.
- Reset clears everything: all level outputs 0, `code_update` 0, pendings 0, counters 0, stage-1 valid 0.
  - A sample in flight is discarded.
  - Partial persistence counts are lost.

## Timing
- Latency: a sample accepted at edge E0 updates the outputs at E1. `code_update` is high during the cycle following E1.
- Throughput: one sample per cycle, sustained.
- Back-to-back samples on the same channel need no bubble. Stage 2 always reads state already updated by the previous sample.
- `sample_ready` rises the first cycle after `rst` deasserts, unless `hold` is high.
- `sample_valid` is ignored while `sample_ready=0`. The upstream must hold data until accepted.
- Threshold boundaries are inclusive upward: d=TH2 exactly gives level 2.
- Saturation case: d=250 with HYST=8 computes 255, not 2.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `sample_valid=1`.
  - All codes stay 00, `code_update=0`, `sample_ready=0`.
  - `sample_ready=1` the cycle after release.
- **Rise with persistence:** ch0 data 130, sent three times.
  - `r1r0` stays 00 after samples 1–2.
  - `r1r0`=10 one edge after sample 3 is accepted, with a single `code_update` pulse.
- **Hysteresis:** from rain=10, send 125 ×3, then 119 ×3.
  - The 125 samples give no change (125+8=133≥128).
  - After the third 119, `r1r0`=01.
- **Interrupted persistence:** ch2 data 200,200,50,200,200,200 every cycle.
  - `w1w0`=11 only after the 6th sample.
  - Exactly one `code_update`.
- **Interleaving:** ch1 70 and ch3 250 alternated every cycle, 3 each.
  - Result `s1s0`=01 and `l1l0`=11.
  - Two separate `code_update` pulses.
  - Rain and wind codes untouched.
- **Hold and reset mid-operation:**
  - Ch0 250 ×2, then `hold` for 4 cycles: no change, `sample_ready=0` throughout.
  - Then `rst` for 1 cycle, then ch0 250 ×1: `r1r0` remains 00, because the counter restarted.
